// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_ctrl_pkg
// Brief    : Shared encodings for the multi-cycle control unit and decoder.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_ctrl_pkg;

  localparam logic [2:0] C_ST_IDLE   = 3'd0;
  localparam logic [2:0] C_ST_FETCH  = 3'd1;
  localparam logic [2:0] C_ST_DECODE = 3'd2;
  localparam logic [2:0] C_ST_EXEC   = 3'd3;
  localparam logic [2:0] C_ST_MEM    = 3'd4;
  localparam logic [2:0] C_ST_WB     = 3'd5;
  localparam logic [2:0] C_ST_TRAP   = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE   = C_ST_IDLE,
    ST_FETCH  = C_ST_FETCH,
    ST_DECODE = C_ST_DECODE,
    ST_EXEC   = C_ST_EXEC,
    ST_MEM    = C_ST_MEM,
    ST_WB     = C_ST_WB,
    ST_TRAP   = C_ST_TRAP
  } state_t;

  localparam logic [5:0] C_OP_RTYPE = 6'b000000;
  localparam logic [5:0] C_OP_ADDI  = 6'b001000;
  localparam logic [5:0] C_OP_LW    = 6'b100011;
  localparam logic [5:0] C_OP_SW    = 6'b101011;
  localparam logic [5:0] C_OP_BEQ   = 6'b000100;
  localparam logic [5:0] C_OP_J     = 6'b000010;

  localparam logic [5:0] C_FN_ADD = 6'b100000;
  localparam logic [5:0] C_FN_SUB = 6'b100010;
  localparam logic [5:0] C_FN_AND = 6'b100100;
  localparam logic [5:0] C_FN_OR  = 6'b100101;
  localparam logic [5:0] C_FN_SLT = 6'b101010;

  localparam logic [1:0] C_PC_PLUS4  = 2'd0;
  localparam logic [1:0] C_PC_BRANCH = 2'd1;
  localparam logic [1:0] C_PC_JUMP   = 2'd2;

  localparam logic [1:0] C_EXC_NONE     = 2'd0;
  localparam logic [1:0] C_EXC_ILLEGAL  = 2'd1;
  localparam logic [1:0] C_EXC_OVERFLOW = 2'd2;
  localparam logic [1:0] C_EXC_TIMEOUT  = 2'd3;

  typedef enum logic [3:0] {
    CLS_ADD  = 4'd0,
    CLS_SUB  = 4'd1,
    CLS_AND  = 4'd2,
    CLS_OR   = 4'd3,
    CLS_SLT  = 4'd4,
    CLS_ADDI = 4'd5,
    CLS_LW   = 4'd6,
    CLS_SW   = 4'd7,
    CLS_BEQ  = 4'd8,
    CLS_J    = 4'd9
  } instr_cls_t;

  function automatic logic cls_is_rtype(input instr_cls_t cls);
    return cls inside {CLS_ADD, CLS_SUB, CLS_AND, CLS_OR, CLS_SLT};
  endfunction

  function automatic logic cls_uses_imm(input instr_cls_t cls);
    return cls inside {CLS_ADDI, CLS_LW, CLS_SW};
  endfunction

  // Only the signed arithmetic forms trap on overflow; slt and logic ops never do.
  function automatic logic cls_traps_ovf(input instr_cls_t cls);
    return cls inside {CLS_ADD, CLS_SUB, CLS_ADDI};
  endfunction

endpackage
`default_nettype wire

// File: rtl/instr_decode.sv
`default_nettype none
// ============================================================================
// Module   : instr_decode
// Brief    : Combinational opcode/funct classifier with illegal-encoding flag.
// Revision : 1.0 - initial release
// ============================================================================
module instr_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_funct,
  output instr_cls_t o_cls,
  output logic       o_illegal
);

  always_comb begin
    o_cls     = CLS_ADD;
    o_illegal = 1'b0;
    case (i_opcode)
      C_OP_RTYPE: begin
        case (i_funct)
          C_FN_ADD: o_cls = CLS_ADD;
          C_FN_SUB: o_cls = CLS_SUB;
          C_FN_AND: o_cls = CLS_AND;
          C_FN_OR:  o_cls = CLS_OR;
          C_FN_SLT: o_cls = CLS_SLT;
          default:  o_illegal = 1'b1;
        endcase
      end
      C_OP_ADDI: o_cls = CLS_ADDI;
      C_OP_LW:   o_cls = CLS_LW;
      C_OP_SW:   o_cls = CLS_SW;
      C_OP_BEQ:  o_cls = CLS_BEQ;
      C_OP_J:    o_cls = CLS_J;
      default:   o_illegal = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_ctrl
// Brief    : FETCH/DECODE/EXEC/MEM/WB sequencer with trap and retire tracking.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             Zero,
  input  logic             Overflow,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             ir_load,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic             reg_we,
  output logic             reg_dst,
  output logic             alu_src,
  output logic             mem_read,
  output logic             mem_write,
  output logic             mem_to_reg,
  output logic             busy,
  output logic [1:0]       exc_cause,
  output logic [CNT_W-1:0] retired
);

  localparam int C_WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [C_WAIT_W-1:0] C_WAIT_LAST = C_WAIT_W'(TIMEOUT - 1);

  state_t              r_state, w_state_nxt;
  instr_cls_t          r_cls, w_cls_dec;
  logic                w_illegal;
  logic [C_WAIT_W-1:0] r_wait, w_wait_nxt;
  logic [1:0]          r_exc, w_exc_nxt;
  logic [CNT_W-1:0]    r_retired;
  logic                w_retire;

  instr_decode u_decode (
    .i_opcode  (opcode),
    .i_funct   (funct),
    .o_cls     (w_cls_dec),
    .o_illegal (w_illegal)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_cls     <= CLS_ADD;
      r_wait    <= '0;
      r_exc     <= C_EXC_NONE;
      r_retired <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_wait  <= w_wait_nxt;
      r_exc   <= w_exc_nxt;
      if (r_state == ST_DECODE) r_cls <= w_cls_dec;
      if (w_retire) r_retired <= r_retired + CNT_W'(1);
    end
  end

  // Wait counter defaults to zero so it restarts on every entry to FETCH or MEM.
  always_comb begin
    w_state_nxt = r_state;
    w_exc_nxt   = r_exc;
    w_wait_nxt  = '0;
    w_retire    = 1'b0;
    imem_req    = 1'b0;
    ir_load     = 1'b0;
    pc_we       = 1'b0;
    pc_sel      = C_PC_PLUS4;
    reg_we      = 1'b0;
    reg_dst     = 1'b0;
    alu_src     = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_to_reg  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) w_state_nxt = ST_FETCH;
      end
      ST_TRAP: begin
        if (start) begin
          w_exc_nxt   = C_EXC_NONE;
          w_state_nxt = ST_FETCH;
        end
      end
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_load     = 1'b1;
          pc_we       = 1'b1;
          pc_sel      = C_PC_PLUS4;
          w_state_nxt = ST_DECODE;
        end else if (r_wait == C_WAIT_LAST) begin
          w_exc_nxt   = C_EXC_TIMEOUT;
          w_state_nxt = ST_TRAP;
        end else begin
          w_wait_nxt = r_wait + C_WAIT_W'(1);
        end
      end
      ST_DECODE: begin
        if (w_illegal) begin
          w_exc_nxt   = C_EXC_ILLEGAL;
          w_state_nxt = ST_TRAP;
        end else begin
          w_state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        alu_src = cls_uses_imm(r_cls);
        case (r_cls)
          CLS_BEQ: begin
            if (Zero) begin
              pc_we  = 1'b1;
              pc_sel = C_PC_BRANCH;
            end
            w_retire    = 1'b1;
            w_state_nxt = ST_FETCH;
          end
          CLS_J: begin
            pc_we       = 1'b1;
            pc_sel      = C_PC_JUMP;
            w_retire    = 1'b1;
            w_state_nxt = ST_FETCH;
          end
          CLS_LW, CLS_SW: w_state_nxt = ST_MEM;
          default: begin
            if (cls_traps_ovf(r_cls) && Overflow) begin
              w_exc_nxt   = C_EXC_OVERFLOW;
              w_state_nxt = ST_TRAP;
            end else begin
              w_state_nxt = ST_WB;
            end
          end
        endcase
      end
      ST_MEM: begin
        mem_read  = (r_cls == CLS_LW);
        mem_write = (r_cls == CLS_SW);
        if (dmem_ready) begin
          if (r_cls == CLS_LW) begin
            w_state_nxt = ST_WB;
          end else begin
            w_retire    = 1'b1;
            w_state_nxt = ST_FETCH;
          end
        end else if (r_wait == C_WAIT_LAST) begin
          w_exc_nxt   = C_EXC_TIMEOUT;
          w_state_nxt = ST_TRAP;
        end else begin
          w_wait_nxt = r_wait + C_WAIT_W'(1);
        end
      end
      ST_WB: begin
        reg_we      = 1'b1;
        reg_dst     = cls_is_rtype(r_cls);
        mem_to_reg  = (r_cls == CLS_LW);
        w_retire    = 1'b1;
        w_state_nxt = ST_FETCH;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign busy      = (r_state != ST_IDLE) && (r_state != ST_TRAP);
  assign exc_cause = r_exc;
  assign retired   = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_ctrl
// Brief    : Randomized instruction-stream bench with a phase-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl;

  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 4;

  logic             clk = 1'b0;
  logic             reset, start, Zero, Overflow, imem_ready, dmem_ready;
  logic [5:0]       opcode, funct;
  logic             imem_req, ir_load, pc_we, reg_we, reg_dst, alu_src;
  logic             mem_read, mem_write, mem_to_reg, busy;
  logic [1:0]       pc_sel, exc_cause;
  logic [CNT_W-1:0] retired;

  always #5 clk = ~clk;

  multicycle_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode), .funct(funct),
    .Zero(Zero), .Overflow(Overflow), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .ir_load(ir_load), .pc_we(pc_we), .pc_sel(pc_sel),
    .reg_we(reg_we), .reg_dst(reg_dst), .alu_src(alu_src), .mem_read(mem_read),
    .mem_write(mem_write), .mem_to_reg(mem_to_reg), .busy(busy),
    .exc_cause(exc_cause), .retired(retired)
  );

  typedef struct packed {
    logic       imem_req;
    logic       ir_load;
    logic       pc_we;
    logic [1:0] pc_sel;
    logic       reg_we;
    logic       reg_dst;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       busy;
    logic [1:0] exc;
  } outv_t;

  typedef struct {
    logic             start, imem_ready, dmem_ready, zero, ovf;
    logic [5:0]       opcode, funct;
    outv_t            exp;
    logic [CNT_W-1:0] exp_ret;
  } cyc_t;

  typedef enum int {
    K_ADD, K_SUB, K_AND, K_OR, K_SLT, K_ADDI, K_LW, K_SW, K_BEQ, K_J,
    K_BADOP, K_BADOPR, K_BADFN
  } kind_t;

  cyc_t             q[$];
  int               n_checks = 0;
  int               n_errors = 0;
  logic             m_halted;
  logic [1:0]       m_exc;
  logic [CNT_W-1:0] m_ret;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: observed=0x%0h expected=0x%0h", tag, $time, obs, exp);
    end
  endtask

  function automatic outv_t obs_outs();
    return {imem_req, ir_load, pc_we, pc_sel, reg_we, reg_dst, alu_src,
            mem_read, mem_write, mem_to_reg, busy, exc_cause};
  endfunction

  function automatic logic legal_op(input logic [5:0] op);
    return op inside {6'b000000, 6'b001000, 6'b100011, 6'b101011, 6'b000100, 6'b000010};
  endfunction

  function automatic logic legal_fn(input logic [5:0] fn);
    return fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  endfunction

  task automatic encode(input kind_t k, output logic [5:0] op, output logic [5:0] fn);
    op = 6'b000000;
    fn = 6'($urandom);
    case (k)
      K_ADD:   fn = 6'b100000;
      K_SUB:   fn = 6'b100010;
      K_AND:   fn = 6'b100100;
      K_OR:    fn = 6'b100101;
      K_SLT:   fn = 6'b101010;
      K_ADDI:  op = 6'b001000;
      K_LW:    op = 6'b100011;
      K_SW:    op = 6'b101011;
      K_BEQ:   op = 6'b000100;
      K_J:     op = 6'b000010;
      K_BADOP: op = 6'b111111;
      K_BADOPR: begin
        op = 6'($urandom);
        while (legal_op(op)) op = 6'($urandom);
      end
      default: while (legal_fn(fn)) fn = 6'($urandom);
    endcase
  endtask

  // Every cycle starts with random don't-care inputs and an all-quiet busy expectation.
  function automatic cyc_t rand_cyc();
    cyc_t c;
    c.start      = 1'b0;
    c.imem_ready = 1'($urandom);
    c.dmem_ready = 1'($urandom);
    c.zero       = 1'($urandom);
    c.ovf        = 1'($urandom);
    c.opcode     = 6'($urandom);
    c.funct      = 6'($urandom);
    c.exp        = '0;
    c.exp.busy   = 1'b1;
    c.exp.exc    = m_exc;
    c.exp_ret    = m_ret;
    return c;
  endfunction

  task automatic trap(input logic [1:0] cause);
    m_exc    = cause;
    m_halted = 1'b1;
  endtask

  // Expected per-cycle trace of one instruction, built from its phase sequence.
  task automatic gen_instr(input kind_t k, input int fd, input int md, input logic z,
                           input logic ov, input int idle_n);
    cyc_t c;
    logic [5:0] op, fn;
    logic is_r, is_mem;
    encode(k, op, fn);
    is_r   = k inside {K_ADD, K_SUB, K_AND, K_OR, K_SLT};
    is_mem = k inside {K_LW, K_SW};
    if (m_halted) begin
      for (int i = 0; i < idle_n; i++) begin
        c = rand_cyc(); c.exp.busy = 1'b0; q.push_back(c);
      end
      c = rand_cyc(); c.exp.busy = 1'b0; c.start = 1'b1; q.push_back(c);
      m_exc = 2'd0; m_halted = 1'b0;
    end
    for (int i = 0; i < fd && i < TIMEOUT; i++) begin
      c = rand_cyc(); c.imem_ready = 1'b0; c.opcode = op; c.funct = fn;
      c.exp.imem_req = 1'b1; q.push_back(c);
    end
    if (fd >= TIMEOUT) begin trap(2'd3); return; end
    c = rand_cyc(); c.imem_ready = 1'b1; c.opcode = op; c.funct = fn;
    c.exp.imem_req = 1'b1; c.exp.ir_load = 1'b1; c.exp.pc_we = 1'b1; c.exp.pc_sel = 2'd0;
    q.push_back(c);
    c = rand_cyc(); c.opcode = op; c.funct = fn; q.push_back(c);
    if (k inside {K_BADOP, K_BADOPR, K_BADFN}) begin trap(2'd1); return; end
    c = rand_cyc(); c.zero = z; c.ovf = ov;
    c.exp.alu_src = k inside {K_ADDI, K_LW, K_SW};
    if (k == K_BEQ) begin
      c.exp.pc_we = z; c.exp.pc_sel = z ? 2'd1 : 2'd0;
    end else if (k == K_J) begin
      c.exp.pc_we = 1'b1; c.exp.pc_sel = 2'd2;
    end
    q.push_back(c);
    if ((k inside {K_ADD, K_SUB, K_ADDI}) && ov) begin trap(2'd2); return; end
    if (k inside {K_BEQ, K_J}) begin m_ret++; return; end
    if (is_mem) begin
      for (int i = 0; i <= md && i < TIMEOUT; i++) begin
        c = rand_cyc(); c.dmem_ready = (i == md);
        c.exp.mem_read = (k == K_LW); c.exp.mem_write = (k == K_SW); q.push_back(c);
      end
      if (md >= TIMEOUT) begin trap(2'd3); return; end
      if (k == K_SW) begin m_ret++; return; end
    end
    c = rand_cyc(); c.exp.reg_we = 1'b1; c.exp.reg_dst = is_r; c.exp.mem_to_reg = (k == K_LW);
    q.push_back(c);
    m_ret++;
  endtask

  // Drives each queued cycle after the edge and checks it on the falling edge.
  task automatic run_queue(input int max_n);
    cyc_t c;
    int n;
    n = 0;
    while (q.size() > 0 && (max_n < 0 || n < max_n)) begin
      c = q.pop_front();
      start = c.start; imem_ready = c.imem_ready; dmem_ready = c.dmem_ready;
      Zero = c.zero; Overflow = c.ovf; opcode = c.opcode; funct = c.funct;
      @(negedge clk);
      check("outs", 32'(obs_outs()), 32'(c.exp));
      check("retired", 32'(retired), 32'(c.exp_ret));
      @(posedge clk); #1;
      n++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int n_pre;
    reset = 1'b0; start = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b1;
    Zero = 1'b0; Overflow = 1'b0; opcode = '0; funct = '0;
    m_halted = 1'b1; m_exc = 2'd0; m_ret = '0;
    @(negedge clk);
    check("reset_outs", 32'(obs_outs()), 32'd0);
    check("reset_retired", 32'(retired), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    gen_instr(K_ADD,   0,  0, 1'b0, 1'b0, 1);
    gen_instr(K_LW,    0,  3, 1'b0, 1'b0, 0);
    gen_instr(K_SW,    1,  2, 1'b0, 1'b1, 0);
    gen_instr(K_BEQ,   0,  0, 1'b1, 1'b0, 0);
    gen_instr(K_BEQ,   0,  0, 1'b0, 1'b0, 0);
    gen_instr(K_J,     0,  0, 1'b0, 1'b1, 0);
    gen_instr(K_BADOP, 0,  0, 1'b0, 1'b0, 0);
    gen_instr(K_ADDI,  0,  0, 1'b0, 1'b1, 2);
    gen_instr(K_AND,   0,  0, 1'b0, 1'b1, 1);
    gen_instr(K_ADD,  16,  0, 1'b0, 1'b0, 0);
    gen_instr(K_ADD,  15,  0, 1'b0, 1'b0, 1);
    gen_instr(K_LW,    0, 15, 1'b0, 1'b0, 0);
    gen_instr(K_SW,    0, 16, 1'b0, 1'b0, 0);
    run_queue(-1);

    for (int i = 0; i < 200; i++) begin
      kind_t k;
      int fd, md, sel;
      k   = kind_t'($urandom_range(0, 12));
      sel = int'($urandom_range(0, 15));
      fd  = (sel == 0) ? TIMEOUT : (sel == 1) ? TIMEOUT - 1 : int'($urandom_range(0, 3));
      sel = int'($urandom_range(0, 15));
      md  = (sel == 0) ? TIMEOUT : (sel == 1) ? TIMEOUT - 1 : int'($urandom_range(0, 4));
      gen_instr(k, fd, md, 1'($urandom), ($urandom_range(0, 3) == 0),
                int'($urandom_range(0, 2)));
      run_queue(-1);
    end

    // Stop inside the third MEM wait cycle of a load, then reset asynchronously.
    n_pre = m_halted ? 1 : 0;
    gen_instr(K_LW, 0, 10, 1'b0, 1'b0, 0);
    run_queue(n_pre + 5);
    reset = 1'b0; start = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b1;
    @(negedge clk);
    check("rst_mem_outs", 32'(obs_outs()), 32'd0);
    check("rst_mem_retired", 32'(retired), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_hold_outs", 32'(obs_outs()), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1; start = 1'b0;
    q.delete();
    m_halted = 1'b1; m_exc = 2'd0; m_ret = '0;
    gen_instr(K_ADD, 0, 0, 1'b0, 1'b0, 1);
    run_queue(-1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
